// File: rtl/sram_port_sched.sv
// rtl/sram_port_sched.sv - single-port masked-write SRAM scheduler with post-reset zero-fill
module sram_port_sched #(
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] w_mask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIM);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [3:0]        starve_cnt;
  logic              resp_valid_q;
  logic              force_rd;
  logic              w_fire;
  logic              r_fire;

  // A waiting read is forced through once writes have held the port STARVE_LIM times in a row.
  assign force_rd = r_valid && (starve_cnt == STARVE_MAX);
  assign w_fire   = w_valid && w_ready;
  assign r_fire   = r_valid && r_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      starve_cnt   <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      resp_valid_q <= r_fire;
      if (state == ST_INIT)
        init_cnt <= init_cnt + 1'b1;
      if (!r_valid || r_fire)
        starve_cnt <= '0;
      else if (w_fire && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    init_done  = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    case (state)
      ST_INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt;
        sram_wmask = '1;
        if (init_cnt == LAST_ADDR)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        init_done = 1'b1;
        w_ready   = !force_rd;
        r_ready   = !w_valid || force_rd;
        // Writes win by default so a later read always observes earlier writes.
        if (w_valid && !force_rd) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = w_addr;
          sram_wmask = w_mask;
          sram_wdata = w_data;
        end else if (r_valid) begin
          sram_en   = 1'b1;
          sram_addr = r_addr;
        end
      end
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_valid_q ? sram_rdata : '0;

  a_w_addr_range: assert property (@(posedge clock) disable iff (reset)
    !(w_fire && int'(w_addr) >= DEPTH));
  a_r_addr_range: assert property (@(posedge clock) disable iff (reset)
    !(r_fire && int'(r_addr) >= DEPTH));

endmodule
